// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with registered result/flags, shifts and signed compare.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier (opcode 1010).
module alu_multicycle #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOR = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1001;

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1010;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_BUSY, ST_DONE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
`endif

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_carry;
   logic             r_overflow;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_op;

   logic [WIDTH-1:0] w_res;
   logic             w_cy;
   logic             w_ov;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [SHW-1:0]   w_sh;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW-1:0]     r_cnt;
   logic [WIDTH:0]     w_step;

   // Right-shifting multiplier: low half starts as b and is consumed LSB first.
   assign w_step = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
`endif

   assign w_sum = {1'b0, r_a} + {1'b0, r_b};
   assign w_dif = {1'b0, r_a} - {1'b0, r_b};
   assign w_sh  = r_b[SHW-1:0];

   always_comb begin
      w_res = '0;
      w_cy  = 1'b0;
      w_ov  = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_cy  = w_sum[WIDTH];
            w_ov  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_dif[WIDTH-1:0];
            w_cy  = ~w_dif[WIDTH];
            w_ov  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_XOR: w_res = r_a ^ r_b;
         OP_NOR: w_res = ~(r_a | r_b);
         OP_SLL: w_res = r_a << w_sh;
         OP_SRL: w_res = r_a >> w_sh;
         OP_SRA: w_res = $unsigned($signed(r_a) >>> w_sh);
         OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
`ifdef ALU_MUL_EN
         OP_MUL: begin
            w_res = r_acc[WIDTH-1:0];
            w_cy  = |r_acc[2*WIDTH-1:WIDTH];
         end
`endif
         default: w_res = '0;
      endcase
   end

   // Operand capture at acceptance; no reset needed on pure datapath registers.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && in_valid) begin
         r_a  <= a;
         r_b  <= b;
         r_op <= op;
`ifdef ALU_MUL_EN
         r_acc <= {{WIDTH{1'b0}}, b};
`endif
      end
`ifdef ALU_MUL_EN
      else if (r_state == ST_BUSY) begin
         r_acc <= {w_step, r_acc[WIDTH-1:1]};
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
`ifdef ALU_MUL_EN
         r_cnt       <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
`ifdef ALU_MUL_EN
                  if (op == OP_MUL) begin
                     r_state <= ST_BUSY;
                     r_cnt   <= SHW'(WIDTH-1);
                  end else begin
                     r_state <= ST_EXEC;
                  end
`else
                  r_state <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               r_result    <= w_res;
               r_carry     <= w_cy;
               r_overflow  <= w_ov;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
`ifdef ALU_MUL_EN
            ST_BUSY: begin
               if (r_cnt == '0) r_state <= ST_EXEC;
               else             r_cnt   <= r_cnt - 1'b1;
            end
`endif
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = (r_result == '0);
   assign negative  = r_result[WIDTH-1];
   assign carry     = r_carry;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH = 32); follows ALU_MUL_EN if defined.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] o_res;
   logic        o_z, o_n, o_c, o_v;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry(carry),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        cy;
      logic        ov;
      int          lat;
   } exp_t;

   // Reference: plain arithmetic on wide integers, not a re-expression of the datapath.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop);
      exp_t        e;
      longint      sa, sb, ss;
      logic [63:0] p;
      int          sh;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      sh = int'(mb & 32'd31);
      e.res = 32'd0; e.cy = 1'b0; e.ov = 1'b0; e.lat = 1;
      case (mop)
         4'd0: begin
            p = {32'd0, ma} + {32'd0, mb};
            e.res = p[31:0]; e.cy = p[32];
            ss = sa + sb; e.ov = (ss != longint'($signed(e.res)));
         end
         4'd1: begin
            e.res = ma - mb; e.cy = (ma >= mb);
            ss = sa - sb; e.ov = (ss != longint'($signed(e.res)));
         end
         4'd2: e.res = ma & mb;
         4'd3: e.res = ma | mb;
         4'd4: e.res = ma ^ mb;
         4'd5: e.res = ~(ma | mb);
         4'd6: e.res = ma << sh;
         4'd7: e.res = ma >> sh;
         4'd8: begin ss = sa >>> sh; e.res = ss[31:0]; end
         4'd9: e.res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
         4'd10: begin
            p = {32'd0, ma} * {32'd0, mb};
            e.res = p[31:0]; e.cy = (p[63:32] != 32'd0); e.lat = 33;
         end
`endif
         default: e.res = 32'd0;
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [3:0] top,
                         input int stall, input string tag);
      exp_t e;
      int   lat;
      e = model(ta, tb_v, top);
      @(negedge clk);
      chk({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
      a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = (stall == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         chk({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
         lat++;
         a = $urandom; b = $urandom;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
      chk({tag, "_result"}, 64'(result), 64'(e.res));
      chk({tag, "_zero"}, 64'(zero), 64'(e.res == 32'd0));
      chk({tag, "_negative"}, 64'(negative), 64'(e.res[31]));
      chk({tag, "_carry"}, 64'(carry), 64'(e.cy));
      chk({tag, "_overflow"}, 64'(overflow), 64'(e.ov));
      chk({tag, "_ready_done"}, 64'(in_ready), 64'd0);
      o_res = result; o_z = zero; o_n = negative; o_c = carry; o_v = overflow;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         a = $urandom; b = $urandom; op = 4'($urandom); in_valid = 1'b1;
         chk({tag, "_stall_result"}, 64'(result), 64'(e.res));
         chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_consumed_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          sel;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", {60'd0, negative, carry, overflow, in_ready}, 64'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      chk("post_rst_valid", 64'(out_valid), 64'd0);

      run_op(32'hFFFF_FFFF, 32'd1, 4'd0, 0, "add_wrap");
      chk("add_wrap_plan", {31'd0, o_res, o_z, o_c, o_v}, {31'd0, 32'd0, 1'b1, 1'b1, 1'b0});
      run_op(32'h7FFF_FFFF, 32'd1, 4'd0, 0, "add_ovf");
      chk("add_ovf_plan", {32'd0, o_res[31:0]}, 64'h8000_0000);
      chk("add_ovf_flags", {62'd0, o_n, o_v}, 64'd3);
      run_op(32'd5, 32'd7, 4'd1, 1, "sub_neg");
      chk("sub_neg_plan", {30'd0, o_res, o_c, o_n}, {30'd0, 32'hFFFF_FFFE, 1'b0, 1'b1});
      run_op(32'hFFFF_FFFF, 32'd1, 4'd9, 0, "slt_signed");
      chk("slt_plan", 64'(o_res), 64'd1);
      run_op(32'h8000_0000, 32'h0000_0024, 4'd8, 0, "sra");
      chk("sra_plan", 64'(o_res), 64'hF800_0000);
      run_op(32'd1, 32'd31, 4'd6, 0, "sll");
      chk("sll_plan", 64'(o_res), 64'h8000_0000);
      run_op(32'h0001_0000, 32'h0001_0000, 4'd10, 0, "mul_hi");
`ifdef ALU_MUL_EN
      chk("mul_plan", {62'd0, o_z, o_c}, 64'd3);
`else
      chk("mul_plan", {62'd0, o_z, o_c}, 64'd2);
`endif
      run_op(32'd3, 32'd4, 4'd0, 5, "stall_add");
      chk("stall_add_plan", 64'(o_res), 64'd7);
      run_op(32'h1234_5678, 32'h0000_0123, 4'd10, 1, "mul_small");
      run_op(32'hDEAD_BEEF, 32'h0000_0001, 4'd13, 0, "undef_op");

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: ra = $urandom;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            default: ra = 32'($urandom_range(0, 15));
         endcase
         rb = (sel == 3) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op(ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd");
      end

      // Asynchronous reset while an operation (a multiply when compiled in) is in flight.
      @(negedge clk);
      a = 32'h0001_0000; b = 32'h0001_0000; op = 4'd10; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_zero", 64'(zero), 64'd1);
      chk("midrst_ready", 64'(in_ready), 64'd1);
      chk("midrst_result", {31'd0, result, carry}, 64'd0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("midrst_no_stale", {62'd0, out_valid, in_ready}, 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
